// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST classifier datapath: FSM encoding,
// default widths and the clamping helpers used by the MAC stages.
package mnist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_OUT} state_e;

  localparam int DEF_N_INPUTS = 784;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_OUT_W    = 8;

  // Clamp to the signed range of a w-bit two's complement value.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_s = hi;
    else if (v < lo) sat_s = lo;
    else             sat_s = v;
  endfunction

  // Clamp to [0, 2^w-1].
  function automatic logic signed [63:0] sat_u(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v > hi)        sat_u = hi;
    else if (v < 64'sd0) sat_u = 64'sd0;
    else               sat_u = v;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Beat/result bus of the single-neuron MAC; master drives beats, slave is the neuron.
interface neuron_mac_if #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 8,
  parameter int IDX_W    = 10
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   pixel;
  logic [WEIGHT_W-1:0] weight;
  logic [ACC_W-1:0]    bias;
  logic [IDX_W-1:0]    idx;
  logic                busy;
  logic                out_valid;
  logic [OUT_W-1:0]    out_data;

  modport master (output start, in_valid, pixel, weight, bias,
                  input  in_ready, idx, busy, out_valid, out_data);
  modport slave  (input  start, in_valid, pixel, weight, bias,
                  output in_ready, idx, busy, out_valid, out_data);
endinterface

// File: rtl/counter.sv
// Wrapping index counter 0..MAX_COUNT-1; done flags the final position.
module counter #(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 784
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             done
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)       count_q <= '0;
    else if (en)   count_q <= done ? '0 : count_q + 1'b1;
  end

  assign count = count_q;
  assign done  = (count_q == WIDTH'(MAX_COUNT - 1));
endmodule

// File: rtl/neuron_mac.sv
// Single-neuron saturating MAC: accumulate pixel*weight beats, add bias, shift,
// activate and clamp. Define NEURON_RELU_EN for ReLU/unsigned output.
module neuron_mac
  import mnist_pkg::*;
#(
  parameter int N_INPUTS   = DEF_N_INPUTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FRAC_SHIFT = 7,
  parameter int IDX_W      = 10
) (
  input  logic       clk,
  input  logic       rst,
  neuron_mac_if.slave bus
);
  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     in_ready_q, busy_q, out_valid_q;
  logic                     accept, last_idx;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W+WEIGHT_W:0] prod;
  logic signed [63:0]       addend, sum, shifted;

  assign accept = in_ready_q & bus.in_valid;

  counter #(.WIDTH(IDX_W), .MAX_COUNT(N_INPUTS)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .count (idx),
    .done  (last_idx)
  );

  // Pixel is unsigned: a zero MSB makes the signed multiply treat it as such.
  assign prod = $signed({1'b0, bus.pixel}) * $signed(bus.weight);

  always_comb begin
    addend  = (state_q == S_BIAS) ? 64'($signed(bus.bias)) : 64'(prod);
    sum     = 64'(acc_q) + addend;
    acc_d   = ACC_W'(sat_s(sum, ACC_W));
    shifted = 64'(acc_q >>> FRAC_SHIFT);
`ifdef NEURON_RELU_EN
    out_data_d = OUT_W'(sat_u(shifted, OUT_W));
`else
    out_data_d = OUT_W'(sat_s(shifted, OUT_W));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          acc_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= S_ACC;
        end
        S_ACC: if (accept) begin
          acc_q <= acc_d;
          if (last_idx) begin
            in_ready_q <= 1'b0;
            state_q    <= S_BIAS;
          end
        end
        S_BIAS: begin
          acc_q   <= acc_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          out_data_q  <= out_data_d;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.idx       = idx;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=4, FRAC_SHIFT=0, IDX_W=2.
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  neuron_mac_if #(.IDX_W(2)) bus ();

  neuron_mac #(.N_INPUTS(4), .FRAC_SHIFT(0), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one evaluation; reports result, edges from last beat to out_valid,
  // number of out_valid strobes, idx seen before each beat and after the last.
  task automatic drive_run(input logic [31:0] px, input logic [31:0] wt, input logic [23:0] b,
                           input int stall, input bit noise, input bit b2b,
                           output logic [7:0] got, output int lat, output int nvalid,
                           output logic [9:0] itr, output logic busy_end, output logic rdy);
    bus.bias  = b;
    bus.start = 1'b1;
    tick();
    bus.start = noise;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int s = 0; s < stall; s++) begin
          bus.in_valid = 1'b0;
          tick();
        end
      end
      itr[i*2 +: 2] = bus.idx;
      bus.pixel    = px[i*8 +: 8];
      bus.weight   = wt[i*8 +: 8];
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    itr[9:8] = bus.idx;
    lat = -1; nvalid = 0; got = '0; rdy = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (b2b && lat > 0 && c == lat + 1) begin
        rdy = bus.in_ready;
        bus.start = 1'b0;
      end
      if (bus.out_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = c;
          got = bus.out_data;
        end
      end
      if (noise && c >= 2) bus.start = 1'b0;
      if (b2b && c == lat) bus.start = 1'b1;
    end
    busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    checks++; if (bus.idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", bus.idx); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] got; int lat, nv; logic [9:0] itr; logic be, rdy;
    drive_run({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 24'd5, 0, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== 8'd15) begin failures++; $display("FAIL basic_data: got %0d expected 15", got); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL basic_strobes: got %0d expected 1", nv); end
    checks++; if (itr !== 10'b00_11_10_01_00) begin failures++; $display("FAIL basic_idx_seq: got %b expected 0011100100", itr); end
    checks++; if (be !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %0b expected 0", be); end
  endtask

  task automatic test_negative();
    logic [7:0] got, exp; int lat, nv; logic [9:0] itr; logic be, rdy;
`ifdef NEURON_RELU_EN
    exp = 8'h00;
`else
    exp = 8'hD8;
`endif
    drive_run({4{8'd10}}, {4{8'hFF}}, 24'd0, 0, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== exp) begin failures++; $display("FAIL negative_sum: got %0h expected %0h", got, exp); end
  endtask

  task automatic test_saturation();
    logic [7:0] got, exp_p, exp_n; int lat, nv; logic [9:0] itr; logic be, rdy;
`ifdef NEURON_RELU_EN
    exp_p = 8'hFF; exp_n = 8'h00;
`else
    exp_p = 8'h7F; exp_n = 8'h80;
`endif
    drive_run({4{8'd255}}, {4{8'h7F}}, 24'd0, 0, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== exp_p) begin failures++; $display("FAIL sat_pos: got %0h expected %0h", got, exp_p); end
    drive_run({4{8'd255}}, {4{8'h80}}, 24'd0, 0, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== exp_n) begin failures++; $display("FAIL sat_neg: got %0h expected %0h", got, exp_n); end
  endtask

  task automatic test_stall();
    logic [7:0] got; int lat, nv; logic [9:0] itr; logic be, rdy;
    drive_run({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 24'd5, 3, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== 8'd15) begin failures++; $display("FAIL stall_data: got %0d expected 15", got); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL stall_latency: got %0d expected 2", lat); end
    checks++; if (itr !== 10'b00_11_10_01_00) begin failures++; $display("FAIL stall_idx_seq: got %b expected 0011100100", itr); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] got; int lat, nv; logic [9:0] itr; logic be, rdy;
    int seen = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.pixel = 8'd7; bus.weight = 8'd3; bus.in_valid = 1'b1;
    tick(); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %0b expected 0", bus.in_ready); end
    checks++; if (bus.idx !== 2'd0) begin failures++; $display("FAIL midrst_idx: got %0d expected 0", bus.idx); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL midrst_out_data: got %0h expected 0", bus.out_data); end
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_valid: got %0d strobes expected 0", seen); end
    drive_run({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 24'd5, 0, 1'b0, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== 8'd15) begin failures++; $display("FAIL midrst_fresh_run: got %0d expected 15", got); end
  endtask

  task automatic test_protocol_noise();
    logic [7:0] got; int lat, nv; logic [9:0] itr; logic be, rdy;
    bus.pixel = 8'd9; bus.weight = 8'd9; bus.in_valid = 1'b1;
    tick(); tick(); tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.idx !== 2'd0) begin failures++; $display("FAIL idle_in_valid_idx: got %0d expected 0", bus.idx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_in_valid_busy: got %0b expected 0", bus.busy); end
    drive_run({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 24'd5, 0, 1'b1, 1'b0, got, lat, nv, itr, be, rdy);
    checks++; if (got !== 8'd15) begin failures++; $display("FAIL noise_data: got %0d expected 15", got); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL noise_strobes: got %0d expected 1", nv); end
    checks++; if (be !== 1'b0) begin failures++; $display("FAIL noise_start_in_out: busy got %0b expected 0", be); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got; int lat, nv; logic [9:0] itr; logic be, rdy;
    logic [7:0] got2 = '0;
    bit found = 1'b0;
    drive_run({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 24'd5, 0, 1'b0, 1'b1, got, lat, nv, itr, be, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_in_ready: got %0b expected 1", rdy); end
    checks++; if (got !== 8'd15) begin failures++; $display("FAIL b2b_first: got %0d expected 15", got); end
    bus.pixel = 8'd1; bus.weight = 8'd2; bus.in_valid = 1'b1;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.out_valid && !found) begin
        found = 1'b1;
        got2 = bus.out_data;
      end
    end
    checks++; if (!found || got2 !== 8'd13) begin failures++; $display("FAIL b2b_second: got %0d (valid seen %0b) expected 13", got2, found); end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.pixel = '0; bus.weight = '0; bus.bias = '0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_stall();
    test_reset_mid_run();
    test_protocol_noise();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
